// File: rtl/xbar_pkg.sv
// Shared crossbar constants and types.
// Lane count, frame length, transmit FSM states and bit-plane words.
package xbar_pkg;
   localparam int ports = 8;
   localparam int slots = 8;

   typedef enum logic {
      TX_IDLE,
      TX_SHIFT
   } tx_state_e;

   typedef logic [7:0][ports-1:0] plane_word_t;
endpackage

// File: rtl/xbar_serial_tx_if.sv
// Parallel word handshake into the serial transmitter.
// The master offers bit-plane words; the slave accepts them.
interface xbar_serial_tx_if
   import xbar_pkg::*;
#(
   parameter int PORTS = ports,
   parameter int WIDTH = 8
);
   logic                        par_valid;
   logic                        par_ready;
   logic [WIDTH-1:0][PORTS-1:0] par_data;

   modport master (
      output par_valid,
      output par_data,
      input  par_ready
   );

   modport slave (
      input  par_valid,
      input  par_data,
      output par_ready
   );
endinterface

// File: rtl/xbar_tx_ctrl.sv
// Transmit control: FSM, shared bit counter, slot tracking,
// underrun flag and the holding-register handshake.
module xbar_tx_ctrl
   import xbar_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int SLOTS = slots,
   localparam int CW    = $clog2(WIDTH),
   localparam int SW    = $clog2(SLOTS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          bit_en,
   input  logic          par_valid,
   input  logic          underrun_clr,
   output logic          par_ready,
   output logic          accept,
   output logic          load,
   output logic          shift,
   output logic          idle,
   output logic          tx_active,
   output logic          word_start,
   output logic          frame_start,
   output logic [SW-1:0] tx_slot,
   output logic          underrun
);
   tx_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] nslot_q, nslot_d;
   logic [SW-1:0] slot_q, slot_d;
   logic          hold_q;
   logic          ws_q, fs_q, ur_q;
   logic          set_ur;

   assign par_ready   = !hold_q;
   assign accept      = par_valid && !hold_q;
   assign tx_active   = state_q == TX_SHIFT;
   assign word_start  = ws_q;
   assign frame_start = fs_q;
   assign tx_slot     = slot_q;
   assign underrun    = ur_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      nslot_d = nslot_q;
      slot_d  = slot_q;
      load    = 1'b0;
      shift   = 1'b0;
      idle    = 1'b0;
      set_ur  = 1'b0;
      if (bit_en) begin
         unique case (state_q)
            TX_IDLE: begin
               if (hold_q) load = 1'b1;
               else        idle = 1'b1;
            end
            TX_SHIFT: begin
               if (cnt_q != '0) begin
                  shift = 1'b1;
                  cnt_d = cnt_q - CW'(1);
               end else if (hold_q) begin
                  load = 1'b1;
               end else begin
                  idle    = 1'b1;
                  state_d = TX_IDLE;
                  // a gap mid-frame restarts framing at slot 0
                  if (nslot_q != '0) begin
                     set_ur  = 1'b1;
                     nslot_d = '0;
                  end
               end
            end
            default: ;
         endcase
         if (load) begin
            state_d = TX_SHIFT;
            cnt_d   = CW'(WIDTH - 1);
            slot_d  = nslot_q;
            nslot_d = (nslot_q == SW'(SLOTS - 1))
                    ? '0 : nslot_q + SW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= TX_IDLE;
         cnt_q   <= '0;
         nslot_q <= '0;
         slot_q  <= '0;
         hold_q  <= 1'b0;
         ws_q    <= 1'b0;
         fs_q    <= 1'b0;
         ur_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         nslot_q <= nslot_d;
         slot_q  <= slot_d;
         if (load)        hold_q <= 1'b0;
         else if (accept) hold_q <= 1'b1;
         ws_q <= load;
         fs_q <= load && (nslot_q == '0);
         if (set_ur)            ur_q <= 1'b1;
         else if (underrun_clr) ur_q <= 1'b0;
      end
   end
endmodule

// File: rtl/xbar_serial_tx.sv
// Serial transmit end of the per-port link: bit-plane words
// out MSB first on PORTS lockstep lanes, one bit per bit_en.
module xbar_serial_tx
   import xbar_pkg::*;
#(
   parameter  int   PORTS    = ports,
   parameter  int   WIDTH    = 8,
   parameter  int   SLOTS    = slots,
   parameter  logic IDLE_BIT = 1'b0,
   localparam int   SW       = $clog2(SLOTS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_en,
   xbar_serial_tx_if.slave  par,
   output logic [PORTS-1:0] serial_out,
   output logic             tx_active,
   output logic             word_start,
   output logic             frame_start,
   output logic [SW-1:0]    tx_slot,
   output logic             underrun,
   input  logic             underrun_clr
);
   logic [WIDTH-1:0][PORTS-1:0] hold_q, shift_q;
   logic accept, load, shift, idle;

   xbar_tx_ctrl #(
      .WIDTH (WIDTH),
      .SLOTS (SLOTS)
   ) u_ctrl (
      .clk          (clk),
      .rst          (rst),
      .bit_en       (bit_en),
      .par_valid    (par.par_valid),
      .underrun_clr (underrun_clr),
      .par_ready    (par.par_ready),
      .accept       (accept),
      .load         (load),
      .shift        (shift),
      .idle         (idle),
      .tx_active    (tx_active),
      .word_start   (word_start),
      .frame_start  (frame_start),
      .tx_slot      (tx_slot),
      .underrun     (underrun)
   );

   // shifter moves whole planes up; plane WIDTH-1 is next on the line
   always_ff @(posedge clk) begin
      if (rst) begin
         serial_out <= {PORTS{IDLE_BIT}};
         hold_q     <= '0;
         shift_q    <= '0;
      end else begin
         if (accept) hold_q <= par.par_data;
         if (load) begin
            serial_out <= hold_q[WIDTH-1];
            shift_q    <= {hold_q[WIDTH-2:0], {PORTS{1'b0}}};
         end else if (shift) begin
            serial_out <= shift_q[WIDTH-1];
            shift_q    <= {shift_q[WIDTH-2:0], {PORTS{1'b0}}};
         end else if (idle) begin
            serial_out <= {PORTS{IDLE_BIT}};
         end
      end
   end
endmodule

// File: tb/tb_xbar_serial_tx.sv
// Bench for xbar_serial_tx: scenario tasks checked against a
// word-queue model of the serial link.
module tb_xbar_serial_tx;
   import xbar_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       bit_en = 1'b0;
   logic       underrun_clr = 1'b0;
   logic [7:0] serial_out;
   logic       tx_active, word_start, frame_start;
   logic [2:0] tx_slot;
   logic       underrun;

   int errors = 0;
   int checks = 0;

   xbar_serial_tx_if bus ();

   xbar_serial_tx dut (
      .clk          (clk),
      .rst          (rst),
      .bit_en       (bit_en),
      .par          (bus),
      .serial_out   (serial_out),
      .tx_active    (tx_active),
      .word_start   (word_start),
      .frame_start  (frame_start),
      .tx_slot      (tx_slot),
      .underrun     (underrun),
      .underrun_clr (underrun_clr)
   );

   always #5 clk = ~clk;

   // model: pending words, word on line, bits still to drive
   plane_word_t m_q[$];
   plane_word_t m_cur;
   int          m_left  = 0;
   logic        m_act   = 1'b0;
   int          m_slot  = 0;
   int          m_nslot = 0;
   logic        m_ur    = 1'b0;
   logic [7:0]  m_out   = '0;
   logic        m_ws    = 1'b0;
   logic        m_fs    = 1'b0;
   logic        m_acc   = 1'b0;

   function automatic plane_word_t rand_plane();
      return plane_word_t'({$urandom(), $urandom()});
   endfunction

   function automatic plane_word_t with_lane(
      plane_word_t w, int p, logic [7:0] v);
      plane_word_t r = w;
      for (int b = 0; b < 8; b++) r[b][p] = v[b];
      return r;
   endfunction

   function automatic logic [7:0] lane_of(plane_word_t w, int p);
      logic [7:0] r;
      for (int b = 0; b < 8; b++) r[b] = w[b][p];
      return r;
   endfunction

   function automatic logic [7:0] pack8(logic q[$], int s);
      logic [7:0] r = '0;
      for (int i = 0; i < 8; i++) r = {r[6:0], q[s+i]};
      return r;
   endfunction

   task automatic cyc();
      logic set;
      @(posedge clk);
      set = 1'b0;
      if (rst) begin
         m_q.delete();
         m_act = 0; m_left = 0; m_slot = 0; m_nslot = 0;
         m_ur = 0; m_out = '0; m_ws = 0; m_fs = 0; m_acc = 0;
      end else begin
         m_acc = bus.par_valid && m_q.size() == 0;
         m_ws = 0;
         m_fs = 0;
         if (bit_en) begin
            if (m_act && m_left > 0) begin
               m_left--;
               m_out = m_cur[m_left];
            end else if (m_q.size() > 0) begin
               m_cur  = m_q.pop_front();
               m_left = 7;
               m_out  = m_cur[7];
               m_act  = 1;
               m_ws   = 1;
               m_slot = m_nslot;
               m_fs   = m_nslot == 0;
               m_nslot = (m_nslot + 1) % 8;
            end else begin
               m_out = '0;
               if (m_act && m_nslot != 0) begin
                  set = 1;
                  m_nslot = 0;
               end
               m_act = 0;
            end
         end
         if (set)               m_ur = 1;
         else if (underrun_clr) m_ur = 0;
         if (m_acc) m_q.push_back(bus.par_data);
      end
      @(negedge clk);
   endtask

   task automatic idle_cycles(int n);
      bus.par_valid = 1'b0;
      bit_en = 1'b1;
      repeat (n) cyc();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.par_valid = 1'b0;
      bus.par_data = '0;
      cyc();
      cyc();
      checks += 7;
      if (serial_out !== 8'h00) begin errors++;
         $display("FAIL reset serial_out got %h want 00", serial_out); end
      if (bus.par_ready !== 1'b1) begin errors++;
         $display("FAIL reset par_ready got %b want 1", bus.par_ready); end
      if (tx_active !== 1'b0) begin errors++;
         $display("FAIL reset tx_active got %b want 0", tx_active); end
      if (word_start !== 1'b0) begin errors++;
         $display("FAIL reset word_start got %b want 0", word_start); end
      if (frame_start !== 1'b0) begin errors++;
         $display("FAIL reset frame_start got %b want 0", frame_start); end
      if (tx_slot !== 3'd0) begin errors++;
         $display("FAIL reset tx_slot got %0d want 0", tx_slot); end
      if (underrun !== 1'b0) begin errors++;
         $display("FAIL reset underrun got %b want 0", underrun); end
      rst = 1'b0;
   endtask

   task automatic test_frame();
      plane_word_t w[8];
      int idx = 0, ws_n = 0, fs_n = 0;
      logic b0[$];
      for (int i = 0; i < 8; i++)
         w[i] = with_lane(rand_plane(), 0, 8'hA5 + 8'(i));
      bit_en = 1'b1;
      for (int c = 0; c < 90; c++) begin
         bus.par_valid = idx < 8;
         if (idx < 8) bus.par_data = w[idx];
         cyc();
         if (m_acc) idx++;
         checks++;
         if (serial_out !== m_out) begin errors++;
            $display("FAIL frame line c=%0d got %h want %h",
                     c, serial_out, m_out); end
         ws_n += int'(word_start);
         fs_n += int'(frame_start);
         if (tx_active) b0.push_back(serial_out[0]);
      end
      bus.par_valid = 1'b0;
      checks += 5;
      if (ws_n != 8) begin errors++;
         $display("FAIL frame word_starts got %0d want 8", ws_n); end
      if (fs_n != 1) begin errors++;
         $display("FAIL frame frame_starts got %0d want 1", fs_n); end
      if (b0.size() != 64) begin errors++;
         $display("FAIL frame active_bits got %0d want 64", b0.size()); end
      while (b0.size() < 64) b0.push_back(1'bx);
      if (pack8(b0, 0) !== 8'hA5) begin errors++;
         $display("FAIL frame first_word got %h want a5", pack8(b0, 0)); end
      if (pack8(b0, 56) !== 8'hAC) begin errors++;
         $display("FAIL frame last_word got %h want ac", pack8(b0, 56)); end
      checks++;
      if (underrun !== 1'b0) begin errors++;
         $display("FAIL frame underrun got %b want 0", underrun); end
   endtask

   task automatic test_slow();
      plane_word_t w = with_lane(rand_plane(), 3, 8'h81);
      logic sent = 1'b0;
      int act_n = 0;
      logic bits[$];
      for (int c = 0; c < 100; c++) begin
         bit_en = (c % 8) == 0;
         bus.par_valid = !sent;
         bus.par_data = w;
         cyc();
         if (m_acc) sent = 1'b1;
         checks++;
         if (serial_out !== m_out) begin errors++;
            $display("FAIL slow line c=%0d got %h want %h",
                     c, serial_out, m_out); end
         if (tx_active) act_n++;
         if (bit_en && tx_active) bits.push_back(serial_out[3]);
      end
      bus.par_valid = 1'b0;
      checks += 2;
      if (act_n != 64) begin errors++;
         $display("FAIL slow active_cycles got %0d want 64", act_n); end
      while (bits.size() < 8) bits.push_back(1'bx);
      if (pack8(bits, 0) !== 8'h81) begin errors++;
         $display("FAIL slow lane3 got %h want 81", pack8(bits, 0)); end
   endtask

   task automatic test_underrun();
      int idx = 0, act_n = 0;
      logic was = 1'b0, seen = 1'b0, got = 1'b0;
      bit_en = 1'b0;
      underrun_clr = 1'b1;
      cyc();
      underrun_clr = 1'b0;
      checks++;
      if (underrun !== 1'b0) begin errors++;
         $display("FAIL ur_clear got %b want 0", underrun); end
      bit_en = 1'b1;
      for (int c = 0; c < 60; c++) begin
         bus.par_valid = idx < 3;
         bus.par_data = rand_plane();
         cyc();
         if (m_acc) idx++;
         if (tx_active) act_n++;
         if (was && !tx_active && !seen) begin
            seen = 1'b1;
            checks += 2;
            if (serial_out !== 8'h00) begin errors++;
               $display("FAIL ur_gap line got %h want 00", serial_out); end
            if (underrun !== 1'b1) begin errors++;
               $display("FAIL ur_gap underrun got %b want 1", underrun); end
         end
         was = tx_active;
      end
      checks += 2;
      if (!seen) begin errors++;
         $display("FAIL ur_gap seen got 0 want 1"); end
      if (act_n != 24) begin errors++;
         $display("FAIL ur_active got %0d want 24", act_n); end
      idx = 0;
      for (int c = 0; c < 20; c++) begin
         bus.par_valid = idx < 1;
         bus.par_data = rand_plane();
         cyc();
         if (m_acc) idx++;
         if (word_start && !got) begin
            got = 1'b1;
            checks += 2;
            if (tx_slot !== 3'd0) begin errors++;
               $display("FAIL ur_restart slot got %0d want 0", tx_slot); end
            if (frame_start !== 1'b1) begin errors++;
               $display("FAIL ur_restart fs got %b want 1", frame_start); end
         end
      end
      checks++;
      if (!got) begin errors++;
         $display("FAIL ur_restart word_start got 0 want 1"); end
      idle_cycles(12);
   endtask

   task automatic test_hold();
      plane_word_t w[3];
      int idx = 0, stall = 0, wsn = 0, ws2_c = -1, acc3_c = -9;
      logic rdy, acc, vld;
      logic bits[$];
      w[0] = rand_plane();
      w[1] = rand_plane();
      w[2] = with_lane(rand_plane(), 0, 8'h3C);
      bit_en = 1'b1;
      for (int c = 0; c < 40; c++) begin
         vld = idx < 3;
         bus.par_valid = vld;
         if (vld) bus.par_data = w[idx];
         rdy = bus.par_ready;
         if (vld && idx == 2 && !rdy) stall++;
         cyc();
         acc = vld && rdy;
         checks++;
         if (acc !== m_acc) begin errors++;
            $display("FAIL hold accept c=%0d got %b want %b",
                     c, acc, m_acc); end
         if (acc) begin
            if (idx == 2) acc3_c = c;
            idx++;
         end
         if (word_start) begin
            wsn++;
            if (wsn == 2) ws2_c = c;
         end
         if (tx_active) bits.push_back(serial_out[0]);
         checks++;
         if (serial_out !== m_out) begin errors++;
            $display("FAIL hold line c=%0d got %h want %h",
                     c, serial_out, m_out); end
      end
      bus.par_valid = 1'b0;
      while (bits.size() < 24) bits.push_back(1'bx);
      checks += 4;
      if (stall != 7) begin errors++;
         $display("FAIL hold stall got %0d want 7", stall); end
      if (acc3_c != ws2_c + 1) begin errors++;
         $display("FAIL hold accept3 got %0d want %0d", acc3_c, ws2_c + 1); end
      if (pack8(bits, 8) !== lane_of(w[1], 0)) begin errors++;
         $display("FAIL hold word2 got %h want %h",
                  pack8(bits, 8), lane_of(w[1], 0)); end
      if (pack8(bits, 16) !== 8'h3C) begin errors++;
         $display("FAIL hold word3 got %h want 3c", pack8(bits, 16)); end
   endtask

   task automatic test_reset_mid();
      int idx = 0, ws_c = -1;
      bit_en = 1'b1;
      for (int c = 0; c < 30; c++) begin
         bus.par_valid = idx < 2;
         bus.par_data = rand_plane();
         cyc();
         if (m_acc) idx++;
         if (word_start && ws_c < 0) ws_c = c;
         if (ws_c >= 0 && c == ws_c + 4) break;
      end
      bus.par_valid = 1'b0;
      checks += 3;
      if (bus.par_ready !== 1'b0) begin errors++;
         $display("FAIL rmid pre ready got %b want 0", bus.par_ready); end
      if (underrun !== 1'b1) begin errors++;
         $display("FAIL rmid pre underrun got %b want 1", underrun); end
      if (tx_active !== 1'b1) begin errors++;
         $display("FAIL rmid pre active got %b want 1", tx_active); end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      checks += 5;
      if (serial_out !== 8'h00) begin errors++;
         $display("FAIL rmid line got %h want 00", serial_out); end
      if (bus.par_ready !== 1'b1) begin errors++;
         $display("FAIL rmid ready got %b want 1", bus.par_ready); end
      if (tx_slot !== 3'd0) begin errors++;
         $display("FAIL rmid slot got %0d want 0", tx_slot); end
      if (underrun !== 1'b0) begin errors++;
         $display("FAIL rmid underrun got %b want 0", underrun); end
      if (tx_active !== 1'b0) begin errors++;
         $display("FAIL rmid active got %b want 0", tx_active); end
      repeat (3) begin
         cyc();
         checks++;
         if (serial_out !== 8'h00) begin errors++;
            $display("FAIL rmid after line got %h want 00", serial_out); end
      end
   endtask

   task automatic test_clr_same();
      logic sent = 1'b0, hit = 1'b0, pred;
      bit_en = 1'b1;
      for (int c = 0; c < 40; c++) begin
         bus.par_valid = !sent;
         bus.par_data = rand_plane();
         pred = m_act && m_left == 0 && m_q.size() == 0 && m_nslot != 0;
         underrun_clr = pred;
         cyc();
         if (m_acc) sent = 1'b1;
         if (pred) begin
            hit = 1'b1;
            checks++;
            if (underrun !== 1'b1) begin errors++;
               $display("FAIL clr_same set_wins got %b want 1", underrun); end
            underrun_clr = 1'b1;
            cyc();
            checks++;
            if (underrun !== 1'b0) begin errors++;
               $display("FAIL clr_same clear got %b want 0", underrun); end
            break;
         end
      end
      underrun_clr = 1'b0;
      bus.par_valid = 1'b0;
      checks++;
      if (!hit) begin errors++;
         $display("FAIL clr_same reached got 0 want 1"); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         bit_en = $urandom_range(0, 3) != 0;
         bus.par_valid = $urandom_range(0, 9) < 6;
         bus.par_data = rand_plane();
         underrun_clr = $urandom_range(0, 19) == 0;
         rst = $urandom_range(0, 199) == 0;
         cyc();
         checks += 7;
         if (serial_out !== m_out) begin errors++;
            $display("FAIL rnd line c=%0d got %h want %h",
                     c, serial_out, m_out); end
         if (bus.par_ready !== (m_q.size() == 0)) begin errors++;
            $display("FAIL rnd ready c=%0d got %b", c, bus.par_ready); end
         if (tx_active !== m_act) begin errors++;
            $display("FAIL rnd active c=%0d got %b want %b",
                     c, tx_active, m_act); end
         if (word_start !== m_ws) begin errors++;
            $display("FAIL rnd ws c=%0d got %b want %b",
                     c, word_start, m_ws); end
         if (frame_start !== m_fs) begin errors++;
            $display("FAIL rnd fs c=%0d got %b want %b",
                     c, frame_start, m_fs); end
         if (tx_slot !== 3'(m_slot)) begin errors++;
            $display("FAIL rnd slot c=%0d got %0d want %0d",
                     c, tx_slot, m_slot); end
         if (underrun !== m_ur) begin errors++;
            $display("FAIL rnd ur c=%0d got %b want %b",
                     c, underrun, m_ur); end
      end
      rst = 1'b0;
      underrun_clr = 1'b0;
      bus.par_valid = 1'b0;
   endtask

   initial begin
      bus.par_valid = 1'b0;
      bus.par_data = '0;
      test_reset();
      test_frame();
      test_slow();
      test_underrun();
      test_hold();
      test_reset_mid();
      test_clr_same();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
